// File: rtl/axis_uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// axis_uart_rx_pkg
// Shared UART definitions used by the transmitter and the receiver:
//   - default frame/divider widths
//   - register address map of the UART control block
//   - parity register layout and the parity helper function
//   - the receive/transmit state encoding
// -----------------------------------------------------------------------------
package axis_uart_rx_pkg;

    // Frame and divider geometry.
    localparam int DATA_WIDTH    = 8;
    localparam int DIVIDER_WIDTH = 32;

    // Register map. The address width is declared first because every
    // address constant below is sized by it.
    localparam int                         UART_ADDR_WIDTH  = 8;
    localparam logic [UART_ADDR_WIDTH-1:0] UART_CTRL_ADDR   = 8'h00;
    localparam logic [UART_ADDR_WIDTH-1:0] UART_DIV_ADDR    = 8'h04;
    localparam logic [UART_ADDR_WIDTH-1:0] UART_PARITY_ADDR = 8'h08;
    localparam logic [UART_ADDR_WIDTH-1:0] UART_STATUS_ADDR = 8'h0C;
    localparam logic [UART_ADDR_WIDTH-1:0] UART_RXDATA_ADDR = 8'h10;
    localparam logic [UART_ADDR_WIDTH-1:0] UART_TXDATA_ADDR = 8'h14;

    // Parity register: the two low bits are {even, odd}.
    typedef struct packed {
        logic [29:0] reserved;
        logic        even;
        logic        odd;
    } uart_parity_reg_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT
    } uart_state_e;

    // Widest payload the parity helper accepts; narrower payloads are
    // zero-extended, which leaves the XOR reduction unchanged.
    localparam int PARITY_MAX_WIDTH = 64;

    // Parity bit expected on the line for a payload. mode is {even, odd};
    // odd wins when both are set, and no parity yields 0.
    function automatic logic parity(input logic [PARITY_MAX_WIDTH-1:0] data,
                                    input logic [1:0]                  mode);
        logic bit_val;
        bit_val = 1'b0;
        if (mode[0]) begin
            bit_val = ~^data;
        end else if (mode[1]) begin
            bit_val = ^data;
        end
        return bit_val;
    endfunction

endpackage

// File: rtl/axis_uart_rx.sv
// -----------------------------------------------------------------------------
// axis_uart_rx
// UART receiver with an AXI-Stream master output holding one byte.
// The serial line is synchronised, start/data/parity/stop bits are recovered
// with a bit timer driven by a latched clocks-per-bit divider, and each good
// byte is presented on m_axis_*. Error conditions produce one-cycle pulses.
//
// Build option:
//   AXIS_UART_RX_MAJORITY_EN - each bit decision is the 2-of-3 majority of the
//   line around the nominal sample point; all timing moves one cycle later.
//
// Ports:
//   clk_i            system clock
//   rst_i            asynchronous active-high reset
//   clk_divider_i    clk_i cycles per bit (values below 4 act as 4)
//   parity_i         {even, odd} parity enable
//   uart_rx_i        serial line, idle high, asynchronous
//   m_axis_tdata_o   received byte
//   m_axis_tvalid_o  byte valid
//   m_axis_tready_i  sink ready
//   parity_err_o     pulse: parity mismatch, byte discarded
//   frame_err_o      pulse: stop bit low, byte discarded
//   overrun_o        pulse: byte dropped because the output register was full
// -----------------------------------------------------------------------------
module axis_uart_rx #(
    parameter int DATA_WIDTH    = axis_uart_rx_pkg::DATA_WIDTH,
    parameter int DIVIDER_WIDTH = axis_uart_rx_pkg::DIVIDER_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [DIVIDER_WIDTH-1:0] clk_divider_i,
    input  logic [1:0]               parity_i,
    input  logic                     uart_rx_i,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata_o,
    output logic                     m_axis_tvalid_o,
    input  logic                     m_axis_tready_i,
    output logic                     parity_err_o,
    output logic                     frame_err_o,
    output logic                     overrun_o
);
    import axis_uart_rx_pkg::*;

    localparam int                     NBITS_W  = $clog2(DATA_WIDTH + 1);
    localparam logic [NBITS_W-1:0]     LAST_BIT = NBITS_W'(DATA_WIDTH - 1);
    localparam logic [DIVIDER_WIDTH-1:0] MIN_DIV = DIVIDER_WIDTH'(4);

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    uart_state_e              state, state_n;
    logic [DIVIDER_WIDTH-1:0] cnt, cnt_n;
    logic [DIVIDER_WIDTH-1:0] div_q, div_n;
    logic [DIVIDER_WIDTH-1:0] half;
    logic [DATA_WIDTH-1:0]    shreg, shreg_n;
    logic [NBITS_W-1:0]       nbits, nbits_n;
    logic                     perr, perr_n;
    logic                     deliver, perr_evt, ferr_evt;

    logic sync_p0, sync_p1, line_p2;
    logic line_now, line_prev, sample;

    // ---- stage p0/p1: two-flop synchronizer, p2+: line history ----
`ifdef AXIS_UART_RX_MAJORITY_EN
    logic line_p3;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            line_p2 <= 1'b1;
            line_p3 <= 1'b1;
        end else begin
            sync_p0 <= uart_rx_i;
            sync_p1 <= sync_p0;
            line_p2 <= sync_p1;
            line_p3 <= line_p2;
        end
    end

    // Edge detection and the timer run one cycle behind the synchronised
    // line, so at each timer sample point the newest line value is the
    // nominal point +1 and the vote covers -1, 0, +1.
    assign line_now  = line_p2;
    assign line_prev = line_p3;
    assign sample    = maj3(sync_p1, line_p2, line_p3);
`else
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            line_p2 <= 1'b1;
        end else begin
            sync_p0 <= uart_rx_i;
            sync_p1 <= sync_p0;
            line_p2 <= sync_p1;
        end
    end

    assign line_now  = sync_p1;
    assign line_prev = line_p2;
    assign sample    = sync_p1;
`endif

    assign half = div_q >> 1;

    // ---- frame FSM: state and bit-timer registers ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
            div_q <= '0;
            shreg <= '0;
            nbits <= '0;
            perr  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            div_q <= div_n;
            shreg <= shreg_n;
            nbits <= nbits_n;
            perr  <= perr_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 1'b1;
        div_n    = div_q;
        shreg_n  = shreg;
        nbits_n  = nbits;
        perr_n   = perr;
        deliver  = 1'b0;
        perr_evt = 1'b0;
        ferr_evt = 1'b0;

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (line_prev && !line_now) begin
                    state_n = START;
                    // Divider is frozen for the whole frame.
                    div_n   = (clk_divider_i < MIN_DIV) ? MIN_DIV : clk_divider_i;
                    nbits_n = '0;
                    perr_n  = 1'b0;
                end
            end
            START: begin
                if (cnt == half - 1'b1) begin
                    cnt_n   = '0;
                    // A line already back high mid-start-bit is a glitch.
                    state_n = sample ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == div_q - 1'b1) begin
                    cnt_n   = '0;
                    shreg_n = {sample, shreg[DATA_WIDTH-1:1]};
                    nbits_n = nbits + 1'b1;
                    if (nbits == LAST_BIT) begin
                        state_n = (parity_i != 2'b00) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (cnt == div_q - 1'b1) begin
                    cnt_n = '0;
                    if (sample != parity(PARITY_MAX_WIDTH'(shreg), parity_i)) begin
                        perr_n = 1'b1;
                    end
                    state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == div_q - 1'b1) begin
                    cnt_n = '0;
                    if (!sample) begin
                        // Framing error masks any parity error.
                        ferr_evt = 1'b1;
                        state_n  = WAIT;
                    end else if (perr) begin
                        perr_evt = 1'b1;
                        state_n  = IDLE;
                    end else begin
                        deliver  = 1'b1;
                        state_n  = IDLE;
                    end
                end
            end
            WAIT: begin
                // Hold through a break so a long low does not retrigger.
                cnt_n = '0;
                if (line_now) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // ---- output stage: one-entry AXIS register and error pulses ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_axis_tdata_o  <= '0;
            m_axis_tvalid_o <= 1'b0;
            parity_err_o    <= 1'b0;
            frame_err_o     <= 1'b0;
            overrun_o       <= 1'b0;
        end else begin
            parity_err_o <= perr_evt;
            frame_err_o  <= ferr_evt;
            overrun_o    <= 1'b0;
            if (deliver) begin
                if (m_axis_tvalid_o && !m_axis_tready_i) begin
                    overrun_o <= 1'b1;
                end else begin
                    // Either empty or draining this cycle: take the new byte.
                    m_axis_tdata_o  <= shreg;
                    m_axis_tvalid_o <= 1'b1;
                end
            end else if (m_axis_tvalid_o && m_axis_tready_i) begin
                m_axis_tvalid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_axis_uart_rx
// Directed bench for axis_uart_rx at 16 clocks per bit. Each task drives one
// scenario on the serial line and compares outputs and event counts against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_axis_uart_rx;
    import axis_uart_rx_pkg::*;

    localparam int DW  = 8;
    localparam int DVW = 32;
    localparam int BIT = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [DVW-1:0] clk_divider = DVW'(BIT);
    logic [1:0]     parity_mode = 2'b00;
    logic           uart_rx = 1'b1;
    logic [DW-1:0]  tdata;
    logic           tvalid;
    logic           tready = 1'b1;
    logic           parity_err;
    logic           frame_err;
    logic           overrun;

    int n_cmp = 0;
    int n_err = 0;

    // Event counters, frozen while reset is asserted.
    int            hs_cnt = 0;
    logic [DW-1:0] hs_data = '0;
    int            vcyc = 0;
    int            pe_cnt = 0;
    int            fe_cnt = 0;
    int            ov_cnt = 0;

    axis_uart_rx #(
        .DATA_WIDTH    (DW),
        .DIVIDER_WIDTH (DVW)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .clk_divider_i   (clk_divider),
        .parity_i        (parity_mode),
        .uart_rx_i       (uart_rx),
        .m_axis_tdata_o  (tdata),
        .m_axis_tvalid_o (tvalid),
        .m_axis_tready_i (tready),
        .parity_err_o    (parity_err),
        .frame_err_o     (frame_err),
        .overrun_o       (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            if (tvalid && tready) begin
                hs_cnt  <= hs_cnt + 1;
                hs_data <= tdata;
            end
            if (tvalid)     vcyc   <= vcyc + 1;
            if (parity_err) pe_cnt <= pe_cnt + 1;
            if (frame_err)  fe_cnt <= fe_cnt + 1;
            if (overrun)    ov_cnt <= ov_cnt + 1;
        end
    end

    // Hold the line at b for n clocks; returns 1 time unit after a rising edge.
    task automatic send_bits(input logic b, input int n);
        uart_rx = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DW-1:0] data, input logic par_en,
                              input logic par_bit, input logic stop_bit);
        send_bits(1'b0, BIT);
        for (int i = 0; i < DW; i++) send_bits(data[i], BIT);
        if (par_en) send_bits(par_bit, BIT);
        send_bits(stop_bit, BIT);
        send_bits(1'b1, 20);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (tdata !== 8'h00) begin n_err++; $display("FAIL reset_tdata got %h want 00", tdata); end
        n_cmp++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got %b want 0", tvalid); end
        n_cmp++; if ({parity_err, frame_err, overrun} !== 3'b000) begin n_err++; $display("FAIL reset_pulses got %b want 000", {parity_err, frame_err, overrun}); end
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (dut.state !== IDLE) begin n_err++; $display("FAIL reset_state got %0d want %0d", dut.state, IDLE); end
        n_cmp++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL post_reset_tvalid got %b want 0", tvalid); end
    endtask

    task automatic test_no_parity();
        int h0, v0, e0;
        parity_mode = 2'b00;
        tready = 1'b1;
        h0 = hs_cnt; v0 = vcyc; e0 = pe_cnt + fe_cnt + ov_cnt;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (hs_cnt - h0 !== 1) begin n_err++; $display("FAIL a5_handshakes got %0d want 1", hs_cnt - h0); end
        n_cmp++; if (hs_data !== 8'hA5) begin n_err++; $display("FAIL a5_tdata got %h want a5", hs_data); end
        n_cmp++; if (vcyc - v0 !== 1) begin n_err++; $display("FAIL a5_tvalid_cycles got %0d want 1", vcyc - v0); end
        n_cmp++; if (pe_cnt + fe_cnt + ov_cnt - e0 !== 0) begin n_err++; $display("FAIL a5_err_pulses got %0d want 0", pe_cnt + fe_cnt + ov_cnt - e0); end
    endtask

    task automatic test_even_parity();
        int h0, p0;
        parity_mode = 2'b10;
        tready = 1'b1;
        h0 = hs_cnt; p0 = pe_cnt;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        n_cmp++; if (hs_cnt - h0 !== 1) begin n_err++; $display("FAIL par_ok_handshakes got %0d want 1", hs_cnt - h0); end
        n_cmp++; if (hs_data !== 8'h3C) begin n_err++; $display("FAIL par_ok_tdata got %h want 3c", hs_data); end
        n_cmp++; if (pe_cnt - p0 !== 0) begin n_err++; $display("FAIL par_ok_perr got %0d want 0", pe_cnt - p0); end
        h0 = hs_cnt; p0 = pe_cnt;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        n_cmp++; if (pe_cnt - p0 !== 1) begin n_err++; $display("FAIL par_bad_perr got %0d want 1", pe_cnt - p0); end
        n_cmp++; if (hs_cnt - h0 !== 0) begin n_err++; $display("FAIL par_bad_handshakes got %0d want 0", hs_cnt - h0); end
        n_cmp++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL par_bad_tvalid got %b want 0", tvalid); end
        parity_mode = 2'b00;
    endtask

    task automatic test_frame_error();
        int h0, f0;
        logic [DW-1:0] d;
        parity_mode = 2'b00;
        tready = 1'b1;
        h0 = hs_cnt; f0 = fe_cnt;
        d = 8'h55;
        send_bits(1'b0, BIT);
        for (int i = 0; i < DW; i++) send_bits(d[i], BIT);
        send_bits(1'b0, 20);
        n_cmp++; if (dut.state !== WAIT) begin n_err++; $display("FAIL ferr_state_wait got %0d want %0d", dut.state, WAIT); end
        send_bits(1'b0, 20);
        n_cmp++; if (dut.state !== WAIT) begin n_err++; $display("FAIL ferr_state_hold got %0d want %0d", dut.state, WAIT); end
        n_cmp++; if (fe_cnt - f0 !== 1) begin n_err++; $display("FAIL ferr_pulses got %0d want 1", fe_cnt - f0); end
        n_cmp++; if (hs_cnt - h0 !== 0) begin n_err++; $display("FAIL ferr_handshakes got %0d want 0", hs_cnt - h0); end
        send_bits(1'b1, 20);
        n_cmp++; if (dut.state !== IDLE) begin n_err++; $display("FAIL ferr_recover_state got %0d want %0d", dut.state, IDLE); end
        send_frame(8'h12, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (hs_cnt - h0 !== 1) begin n_err++; $display("FAIL after_ferr_handshakes got %0d want 1", hs_cnt - h0); end
        n_cmp++; if (hs_data !== 8'h12) begin n_err++; $display("FAIL after_ferr_tdata got %h want 12", hs_data); end
        n_cmp++; if (fe_cnt - f0 !== 1) begin n_err++; $display("FAIL after_ferr_fe_total got %0d want 1", fe_cnt - f0); end
    endtask

    task automatic test_glitch();
        int h0, e0;
        h0 = hs_cnt; e0 = pe_cnt + fe_cnt + ov_cnt;
        send_bits(1'b0, 4);
        send_bits(1'b1, 30);
        n_cmp++; if (hs_cnt - h0 !== 0) begin n_err++; $display("FAIL glitch_handshakes got %0d want 0", hs_cnt - h0); end
        n_cmp++; if (pe_cnt + fe_cnt + ov_cnt - e0 !== 0) begin n_err++; $display("FAIL glitch_err_pulses got %0d want 0", pe_cnt + fe_cnt + ov_cnt - e0); end
        n_cmp++; if (dut.state !== IDLE) begin n_err++; $display("FAIL glitch_state got %0d want %0d", dut.state, IDLE); end
    endtask

    task automatic test_overrun();
        int h0, o0;
        tready = 1'b0;
        h0 = hs_cnt; o0 = ov_cnt;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (tvalid !== 1'b1) begin n_err++; $display("FAIL ovr_first_tvalid got %b want 1", tvalid); end
        n_cmp++; if (tdata !== 8'h11) begin n_err++; $display("FAIL ovr_first_tdata got %h want 11", tdata); end
        n_cmp++; if (ov_cnt - o0 !== 0) begin n_err++; $display("FAIL ovr_first_pulses got %0d want 0", ov_cnt - o0); end
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (tdata !== 8'h11) begin n_err++; $display("FAIL ovr_held_tdata got %h want 11", tdata); end
        n_cmp++; if (tvalid !== 1'b1) begin n_err++; $display("FAIL ovr_held_tvalid got %b want 1", tvalid); end
        n_cmp++; if (ov_cnt - o0 !== 1) begin n_err++; $display("FAIL ovr_pulses got %0d want 1", ov_cnt - o0); end
        tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (hs_cnt - h0 !== 1) begin n_err++; $display("FAIL ovr_drain_handshakes got %0d want 1", hs_cnt - h0); end
        n_cmp++; if (hs_data !== 8'h11) begin n_err++; $display("FAIL ovr_drain_tdata got %h want 11", hs_data); end
        n_cmp++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL ovr_drain_tvalid got %b want 0", tvalid); end
    endtask

    task automatic test_reset_mid_frame();
        int h0, e0;
        tready = 1'b1;
        h0 = hs_cnt; e0 = pe_cnt + fe_cnt + ov_cnt;
        send_bits(1'b0, BIT);
        send_bits(1'b1, 3 * BIT);
        rst = 1'b1;
        uart_rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if ({tvalid, parity_err, frame_err, overrun} !== 4'b0000) begin n_err++; $display("FAIL midrst_ctrl got %b want 0000", {tvalid, parity_err, frame_err, overrun}); end
        n_cmp++; if (tdata !== 8'h00) begin n_err++; $display("FAIL midrst_tdata got %h want 00", tdata); end
        rst = 1'b0;
        send_bits(1'b1, 20);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1);
        send_bits(1'b1, 200);
        n_cmp++; if (hs_cnt - h0 !== 1) begin n_err++; $display("FAIL midrst_handshakes got %0d want 1", hs_cnt - h0); end
        n_cmp++; if (hs_data !== 8'h0F) begin n_err++; $display("FAIL midrst_tdata_after got %h want 0f", hs_data); end
        n_cmp++; if (pe_cnt + fe_cnt + ov_cnt - e0 !== 0) begin n_err++; $display("FAIL midrst_err_pulses got %0d want 0", pe_cnt + fe_cnt + ov_cnt - e0); end
    endtask

    initial begin
        test_reset();
        test_no_parity();
        test_even_parity();
        test_frame_error();
        test_glitch();
        test_overrun();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axis_uart_rx.md
Name: axis_uart_rx

Overview:
- UART receiver and the counterpart of the UART transmitter.
- Samples the asynchronous serial line and recovers start, data, optional parity and stop bits.
- Presents each good byte on an AXI-Stream master with a one-entry output register.
- Sits between the pad and the register/RX FIFO logic; baud divider and parity mode come from the UART control registers.

Parameters:
- DATA_WIDTH, 8, data bits per frame and tdata width.
- DIVIDER_WIDTH, 32, width of the clocks-per-bit divider.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- clk_divider_i  in  DIVIDER_WIDTH  clk_i cycles per bit.
- parity_i  in  2  {even, odd}, per uart_parity_reg_t low bits.
- uart_rx_i  in  1  serial line, idle high, asynchronous to clk_i.
- m_axis_tdata_o  out  DATA_WIDTH  received byte.
- m_axis_tvalid_o  out  1  byte valid.
- m_axis_tready_i  in  1  sink ready.
- parity_err_o  out  1  one-cycle pulse, parity mismatch.
- frame_err_o  out  1  one-cycle pulse, stop bit sampled low.
- overrun_o  out  1  one-cycle pulse, byte dropped because output register full.

Behaviour:
- Reset (async, active-high): state IDLE, synchronizer flops 1, all outputs 0, tdata 0.
- uart_rx_i passes through a 2-flop synchronizer (reset value 1). All logic uses the synchronized line.
- Divider: clk_divider_i is latched on start detection, so changes mid-frame have no effect. Values below 4 are treated as 4.
- Bit timer counts 0..div-1; "half" is floor(div/2).
- States use uart_state_e (IDLE, START, DATA, PARITY, STOP, WAIT).
- IDLE: on a 1->0 transition of the synchronized line, clear the timer and go to START.
- START: at timer == half-1, sample the line.
  - Low: restart the timer, go to DATA.
  - High: glitch, return to IDLE with no output.
- DATA: at timer == div-1, sample the bit and shift LSB-first. After DATA_WIDTH bits, go to PARITY if odd|even, else STOP.
- PARITY:
  - Expected bit = parity(data, mode), using the package function (odd has priority when both set).
  - Sample at div-1. On mismatch, set a pending-error flag. Go to STOP.
- STOP: sample at div-1.
  - Line high and no pending error: deliver the byte, go to IDLE.
  - Line high with pending error: pulse parity_err_o, discard the byte, go to IDLE.
  - Line low: pulse frame_err_o (this takes precedence over the parity error, which is not flagged), discard the byte, go to WAIT.
- WAIT: stay until the synchronized line is high, then go to IDLE. This prevents a break from retriggering.
- Deliver: m_axis_tvalid_o rises the cycle after the stop sample.
  - If tvalid is already high and tready is low, the new byte is dropped, overrun_o pulses, and the held byte is unchanged.
  - If tvalid and tready are both high in the cycle the new byte arrives, the new byte replaces the old one and no overrun is flagged.
- AXIS: tdata and tvalid stay stable while tvalid && !tready; the handshake clears tvalid next cycle. No tlast.
- Latency: start edge to tvalid is about (DATA_WIDTH + 1 + P)*div + half + 3 cycles (2 synchronizer, 1 register), where P is 1 if parity is enabled, else 0.
- Reset mid-frame aborts immediately; the partial byte is discarded and no pulses are emitted.

Optional Feature:
- Macro: AXIS_UART_RX_MAJORITY_EN.
- Defined: each start, data, parity and stop sample is the 2-of-3 majority of the line at the nominal sample point -1, 0 and +1 cycles. The decision is registered at +1, so all sample points and the total latency shift one cycle later.
- Undefined: single sample at the nominal point.

Decomposition:
- Shared package (existing UART package) holds: DATA_WIDTH, DIVIDER_WIDTH, uart_parity_reg_t, the parity function, and uart_state_e, all shared with the transmitter.
- The package must also declare its register address constants in dependency order, before any use.
- No sub-module needed: timer, synchronizer and output register stay inline. An optional tiny sync_2ff cell is acceptable if it already exists.

Test Plan:
- div=16, no parity, send 0xA5 with tready=1: tvalid for one cycle, tdata=0xA5, no error pulses.
- div=16, even parity, send 0x3C with parity bit 0: byte 0x3C delivered. Resend with parity bit 1: parity_err_o pulses once, no tvalid.
- div=16, send 0x55 with stop bit low, line low for 40 cycles then high: frame_err_o pulses once, FSM holds in WAIT, then the next frame 0x12 is received correctly.
- Line low for 4 cycles only (div=16): no tvalid, no error pulses, FSM back in IDLE.
- tready=0, send 0x11 then 0x22: tdata stays 0x11, overrun_o pulses at 0x22's stop; raise tready: one handshake of 0x11.
- Assert rst_i mid-DATA of 0xFF, release, send 0x0F: all outputs 0 during reset; only 0x0F is delivered.
